// File: rtl/alu_arb.sv
// Round-robin arbiter/sequencer sharing one combinational ALU between two requesters.
// Optional `ALU_ARB_STATS_EN adds a saturating count of completed responses on op_cnt_o.
module alu_arb #(
  parameter int DATA_W = 8,
  parameter int OP_W   = 3
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req0_valid_i,
  output logic              req0_ready_o,
  input  logic [DATA_W-1:0] req0_a_i,
  input  logic [DATA_W-1:0] req0_b_i,
  input  logic [OP_W-1:0]   req0_op_i,
  input  logic              req1_valid_i,
  output logic              req1_ready_o,
  input  logic [DATA_W-1:0] req1_a_i,
  input  logic [DATA_W-1:0] req1_b_i,
  input  logic [OP_W-1:0]   req1_op_i,
  output logic [DATA_W-1:0] alu_a_o,
  output logic [DATA_W-1:0] alu_b_o,
  output logic [OP_W-1:0]   alu_op_o,
  input  logic [DATA_W-1:0] alu_res_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic              rsp_id_o,
  output logic [DATA_W-1:0] rsp_res_o,
  output logic              rsp_err_o
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0]       op_cnt_o
`endif
);

  localparam logic [OP_W-1:0] OP_RSVD = OP_W'(7);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e            state_q;
  logic              last_q;
  logic              id_q;
  logic              err_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] a_q, b_q, res_q;
  logic [OP_W-1:0]   op_q;

  logic              gnt_vld;
  logic              gnt_id;
  logic [DATA_W-1:0] sel_a, sel_b;
  logic [OP_W-1:0]   sel_op;
  logic              sel_rsvd;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = 1'b0;
    if (state_q == IDLE) begin
      if (req0_valid_i && req1_valid_i) begin
        gnt_vld = 1'b1;
        gnt_id  = ~last_q;
      end else if (req0_valid_i) begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b0;
      end else if (req1_valid_i) begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b1;
      end
    end
  end

  // Ready depends only on valids, state and last_q; the grant is the handshake.
  assign req0_ready_o = gnt_vld & ~gnt_id;
  assign req1_ready_o = gnt_vld &  gnt_id;

  assign sel_a    = gnt_id ? req1_a_i  : req0_a_i;
  assign sel_b    = gnt_id ? req1_b_i  : req0_b_i;
  assign sel_op   = gnt_id ? req1_op_i : req0_op_i;
  assign sel_rsvd = (sel_op == OP_RSVD);

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      id_q        <= 1'b0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      res_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_vld) begin
            a_q     <= sel_a;
            b_q     <= sel_b;
            // A reserved opcode never reaches the ALU.
            op_q    <= sel_rsvd ? '0 : sel_op;
            id_q    <= gnt_id;
            last_q  <= gnt_id;
            err_q   <= sel_rsvd;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          res_q       <= err_q ? '0 : alu_res_i;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alu_a_o     = a_q;
  assign alu_b_o     = b_q;
  assign alu_op_o    = op_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = id_q;
  assign rsp_res_o   = res_q;
  assign rsp_err_o   = err_q;

`ifdef ALU_ARB_STATS_EN
  logic [15:0] op_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_cnt_q <= '0;
    end else if (rsp_valid_q && rsp_ready_i && (op_cnt_q != 16'hFFFF)) begin
      op_cnt_q <= op_cnt_q + 16'd1;
    end
  end

  assign op_cnt_o = op_cnt_q;
`endif

endmodule

// File: tb/tb_alu_arb.sv
// Self-checking bench for alu_arb: ALU stub, scoreboard of expected responses, directed scenarios.
// Define ALU_ARB_STATS_EN for both files to exercise op_cnt_o.
module tb_alu_arb;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0] req0_op, req1_op;
  logic [7:0] alu_a, alu_b, alu_res;
  logic [2:0] alu_op;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [7:0] rsp_res;
`ifdef ALU_ARB_STATS_EN
  logic [15:0] op_cnt;
`endif

  typedef struct packed {
    logic       id;
    logic [7:0] res;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  alu_arb dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .req0_valid_i(req0_valid),
    .req0_ready_o(req0_ready),
    .req0_a_i    (req0_a),
    .req0_b_i    (req0_b),
    .req0_op_i   (req0_op),
    .req1_valid_i(req1_valid),
    .req1_ready_o(req1_ready),
    .req1_a_i    (req1_a),
    .req1_b_i    (req1_b),
    .req1_op_i   (req1_op),
    .alu_a_o     (alu_a),
    .alu_b_o     (alu_b),
    .alu_op_o    (alu_op),
    .alu_res_i   (alu_res),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_id_o    (rsp_id),
    .rsp_res_o   (rsp_res),
    .rsp_err_o   (rsp_err)
`ifdef ALU_ARB_STATS_EN
    ,
    .op_cnt_o    (op_cnt)
`endif
  );

  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [2:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return a << 1;
      3'd6:    return a >> 1;
      default: return 8'h00;
    endcase
  endfunction

  assign alu_res = alu_f(alu_a, alu_b, alu_op);

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic exp_t make_exp(input logic id, input logic [7:0] a, input logic [7:0] b,
                                    input logic [2:0] op);
    exp_t e;
    e.id  = id;
    e.err = (op == 3'd7);
    e.res = e.err ? 8'h00 : alu_f(a, b, op);
    return e;
  endfunction

  // Scoreboard: push on request handshakes, pop and compare on response handshakes.
  always @(negedge clk) begin
    if (rst_ni) begin
      check("ready_onehot", {31'd0, req0_ready & req1_ready}, 0);
      if (req0_valid && req0_ready) sb.push_back(make_exp(1'b0, req0_a, req0_b, req0_op));
      if (req1_valid && req1_ready) sb.push_back(make_exp(1'b1, req1_a, req1_b, req1_op));
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", rsp_valid, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("sb_id",  rsp_id,  e.id);
          check("sb_res", rsp_res, e.res);
          check("sb_err", rsp_err, e.err);
        end
      end
    end
  end

  task automatic drive_tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive_tick();
    rst_ni = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #2 rst_ni = 1'b1;
  endtask

  task automatic wait_drain();
    logic done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      sample();
      done = (sb.size() == 0) && !rsp_valid;
    end
    check("drain", done, 1);
  endtask

  task automatic do_op(input logic id, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] op);
    logic hs = 1'b0;
    drive_tick();
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
    end
    for (int i = 0; i < 10 && !hs; i++) begin
      sample();
      hs = id ? (req1_valid & req1_ready) : (req0_valid & req0_ready);
      if (!hs) drive_tick();
    end
    check("op_handshake", hs, 1);
    drive_tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_drain();
  endtask

  initial begin
    int   n_rsp;
    logic ids[3];
    logic drop1;
    logic seen;

    rst_ni = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
    rsp_ready = 1'b1;

    // Reset values
    #12;
    check("rst_ready0",    req0_ready, 0);
    check("rst_ready1",    req1_ready, 0);
    check("rst_alu_a",     alu_a,      0);
    check("rst_alu_b",     alu_b,      0);
    check("rst_alu_op",    alu_op,     0);
    check("rst_rsp_valid", rsp_valid,  0);
    check("rst_rsp_id",    rsp_id,     0);
    check("rst_rsp_res",   rsp_res,    0);
    check("rst_rsp_err",   rsp_err,    0);
    @(posedge clk);
    #2 rst_ni = 1'b1;

    // Single request with latency checks
    drive_tick();
    req0_valid = 1'b1; req0_a = 8'd10; req0_b = 8'd3; req0_op = 3'd0;
    sample();
    check("single_hs_N", req0_ready, 1);
    drive_tick();
    req0_valid = 1'b0;
    sample();
    check("single_alu_a_N1",  alu_a,     8'd10);
    check("single_alu_b_N1",  alu_b,     8'd3);
    check("single_alu_op_N1", alu_op,    3'd0);
    check("single_vld_N1",    rsp_valid, 0);
    drive_tick();
    sample();
    check("single_vld_N2", rsp_valid, 1);
    check("single_res",    rsp_res,   8'd13);
    check("single_id",     rsp_id,    0);
    check("single_err",    rsp_err,   0);
    drive_tick();
    sample();
    check("single_idle", rsp_valid, 0);

    // Tie after reset: 0, then 1, then 0 again while req0 stays valid
    do_reset();
    drive_tick();
    req0_valid = 1'b1; req0_a = 8'd10; req0_b = 8'd3; req0_op = 3'd0;
    req1_valid = 1'b1; req1_a = 8'd10; req1_b = 8'd3; req1_op = 3'd1;
    n_rsp = 0;
    drop1 = 1'b0;
    for (int i = 0; i < 40 && n_rsp < 3; i++) begin
      sample();
      if (req1_valid && req1_ready) drop1 = 1'b1;
      if (rsp_valid && rsp_ready) begin
        ids[n_rsp] = rsp_id;
        n_rsp++;
      end
      if (n_rsp < 3) begin
        drive_tick();
        if (drop1) req1_valid = 1'b0;
      end
    end
    drive_tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("tie_rsp_count", n_rsp, 3);
    check("tie_id0", ids[0], 0);
    check("tie_id1", ids[1], 1);
    check("tie_id2", ids[2], 0);
    wait_drain();

    // Back-pressure in RESP, with req1 (reserved opcode) waiting
    drive_tick();
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 8'd20; req0_b = 8'd5; req0_op = 3'd1;
    sample();
    check("bp_hs", req0_ready, 1);
    drive_tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 8'd9; req1_b = 8'd4; req1_op = 3'd7;
    sample();
    check("bp_exec_ready1", req1_ready, 0);
    drive_tick();
    sample();
    check("bp_resp_vld", rsp_valid, 1);
    for (int i = 0; i < 5; i++) begin
      drive_tick();
      sample();
      check("bp_hold_vld",    rsp_valid,  1);
      check("bp_hold_res",    rsp_res,    8'd15);
      check("bp_hold_id",     rsp_id,     0);
      check("bp_hold_err",    rsp_err,    0);
      check("bp_hold_ready0", req0_ready, 0);
      check("bp_hold_ready1", req1_ready, 0);
    end
    drive_tick();
    rsp_ready = 1'b1;
    sample();
    check("bp_release_vld", rsp_valid, 1);
    drive_tick();
    sample();
    check("bp_idle_vld",    rsp_valid,  0);
    check("bp_idle_ready1", req1_ready, 1);

    // Reserved opcode from req1
    drive_tick();
    req1_valid = 1'b0;
    sample();
    check("rsvd_alu_op", alu_op, 0);
    check("rsvd_alu_a",  alu_a,  8'd9);
    drive_tick();
    sample();
    check("rsvd_vld", rsp_valid, 1);
    check("rsvd_err", rsp_err,   1);
    check("rsvd_res", rsp_res,   0);
    check("rsvd_id",  rsp_id,    1);
    wait_drain();

    // Reset asserted in EXEC
    drive_tick();
    req0_valid = 1'b1; req0_a = 8'd1; req0_b = 8'd2; req0_op = 3'd0;
    sample();
    check("rexec_hs", req0_ready, 1);
    drive_tick();
    req0_valid = 1'b0;
    #2;
    rst_ni = 1'b0;
    sb.delete();
    #1;
    check("rexec_alu_a",   alu_a,     0);
    check("rexec_alu_b",   alu_b,     0);
    check("rexec_alu_op",  alu_op,    0);
    check("rexec_rsp_vld", rsp_valid, 0);
    check("rexec_rsp_res", rsp_res,   0);
    check("rexec_rsp_id",  rsp_id,    0);
    check("rexec_ready0",  req0_ready, 0);
    repeat (2) @(posedge clk);
    #2 rst_ni = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sample();
      if (rsp_valid) seen = 1'b1;
    end
    check("rexec_no_rsp", seen, 0);
    drive_tick();
    req0_valid = 1'b1; req0_a = 8'd10; req0_b = 8'd3; req0_op = 3'd0;
    req1_valid = 1'b1; req1_a = 8'd10; req1_b = 8'd3; req1_op = 3'd1;
    sample();
    check("rexec_tie_ready0", req0_ready, 1);
    check("rexec_tie_ready1", req1_ready, 0);
    drive_tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_drain();
    do_op(1'b1, 8'd10, 8'd3, 3'd1);

    // Ops 0..6, alternating requesters; counter checked when built in
    do_reset();
    for (int i = 0; i < 7; i++) begin
      do_op(i[0], 8'h5A, 8'h33, 3'(i));
    end
`ifdef ALU_ARB_STATS_EN
    check("stats_cnt7", op_cnt, 16'd7);
    do_reset();
    sample();
    check("stats_cnt_rst", op_cnt, 16'd0);
`endif

    check("sb_empty_end", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
